// File: rtl/core_rrv_pkg.sv
// core_rrv_pkg: shared tile-fabric transaction types and fabric arbiter defaults
package core_rrv_pkg;

    localparam int FAB_ARB_NUM_REQ   = 2;
    localparam int FAB_ARB_TAG_DEPTH = 4;

    typedef enum logic [1:0] {
        WR     = 2'd0,
        RD     = 2'd1,
        RD_RSP = 2'd2
    } t_tile_op;

    typedef struct packed {
        t_tile_op    opcode;
        logic [31:0] addr;
        logic [31:0] data;
    } t_tile_trans;

endpackage

// File: rtl/core_rrv_fab_tag_fifo.sv
// core_rrv_fab_tag_fifo: in-order FIFO of requester indices for outstanding reads
//   Clock, RstN      : clock, asynchronous active-low reset
//   Push, PushIdx    : enqueue a requester index (ignored when Full)
//   Pop, Head        : dequeue / oldest entry (Pop ignored when Empty)
//   Full, Empty      : occupancy flags
//   Count            : number of stored entries
module core_rrv_fab_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                     Clock,
    input  logic                     RstN,
    input  logic                     Push,
    input  logic [W-1:0]             PushIdx,
    input  logic                     Pop,
    output logic [W-1:0]             Head,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic          doPush, doPop;

    assign Full   = Count == (AW+1)'(DEPTH);
    assign Empty  = Count == '0;
    assign Head   = mem[rdPtr];
    assign doPush = Push && !Full;
    assign doPop  = Pop && !Empty;

    always_ff @(posedge Clock)
        if (doPush) mem[wrPtr] <= PushIdx;

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            wrPtr <= wrPtr + AW'(doPush);
            rdPtr <= rdPtr + AW'(doPop);
            Count <= Count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

endmodule

// File: rtl/core_rrv_fab_req_arb.sv
// core_rrv_fab_req_arb: round-robin share of the outbound fabric port with read-response routing
//   Clock, RstN                 : clock, asynchronous active-low reset
//   ReqValid/Req/ReqReady       : per-requester transaction handshake (ReqReady combinational)
//   OutFabricValid/OutFabric    : registered outbound transaction, OutReady accepts it
//   InFabricValid/InFabric      : inbound transactions, only RD_RSP consumed
//   RspValid/RspData            : one-hot read-response strobe and data, one cycle after RD_RSP
//   ErrUnexpRsp                 : sticky, RD_RSP seen with no outstanding read
//   TagCount                    : outstanding reads
//   CORE_RRV_FAB_ARB_PMON_EN    : adds saturating PmonGrantCnt/PmonStallCnt/PmonTagFullCnt
module core_rrv_fab_req_arb
    import core_rrv_pkg::*;
#(
    parameter int NUM_REQ   = FAB_ARB_NUM_REQ,
    parameter int TAG_DEPTH = FAB_ARB_TAG_DEPTH
) (
    input  logic                         Clock,
    input  logic                         RstN,
    input  logic [NUM_REQ-1:0]           ReqValid,
    input  t_tile_trans                  Req [NUM_REQ],
    output logic [NUM_REQ-1:0]           ReqReady,
    output logic                         OutFabricValid,
    output t_tile_trans                  OutFabric,
    input  logic                         OutReady,
    input  logic                         InFabricValid,
    input  t_tile_trans                  InFabric,
    output logic [NUM_REQ-1:0]           RspValid,
    output logic [31:0]                  RspData,
    output logic                         ErrUnexpRsp,
    output logic [$clog2(TAG_DEPTH):0]   TagCount
`ifdef CORE_RRV_FAB_ARB_PMON_EN
    ,
    output logic [31:0]                  PmonGrantCnt [NUM_REQ],
    output logic [31:0]                  PmonStallCnt,
    output logic [31:0]                  PmonTagFullCnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      rrPtr, grantIdx, tagHead;
    logic [IW-1:0]      cand [NUM_REQ];
    logic [NUM_REQ-1:0] eligible, isRd;
    logic               grantValid, slotFree, tagFull, tagEmpty, push, rspHit, pop;
    logic [31:0]        unusedInAddr;

    assign unusedInAddr = InFabric.addr;

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot
    for (genvar i = 0; i < NUM_REQ; i++) begin : gReq
        assign isRd[i]     = Req[i].opcode == RD;
        assign eligible[i] = ReqValid[i] && (!isRd[i] || !tagFull);
        assign cand[i]     = IW'((int'(rrPtr) + i) % NUM_REQ);
    end

    assign slotFree = RstN && (!OutFabricValid || OutReady);

    // Scan downward so the candidate closest to the pointer wins
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (slotFree && eligible[cand[k]]) begin
                grantValid = 1'b1;
                grantIdx   = cand[k];
            end
    end

    assign ReqReady = grantValid ? NUM_REQ'(1) << grantIdx : '0;
    assign push     = grantValid && isRd[grantIdx];
    assign rspHit   = InFabricValid && InFabric.opcode == RD_RSP;
    assign pop      = rspHit && !tagEmpty;

    core_rrv_fab_tag_fifo #(
        .DEPTH(TAG_DEPTH),
        .W    (IW)
    ) uTagFifo (
        .Clock  (Clock),
        .RstN   (RstN),
        .Push   (push),
        .PushIdx(grantIdx),
        .Pop    (pop),
        .Head   (tagHead),
        .Full   (tagFull),
        .Empty  (tagEmpty),
        .Count  (TagCount)
    );

    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            rrPtr          <= '0;
            OutFabricValid <= 1'b0;
            OutFabric      <= '0;
            RspValid       <= '0;
            RspData        <= '0;
            ErrUnexpRsp    <= 1'b0;
        end else begin
            if (grantValid) begin
                rrPtr          <= grantIdx == IW'(NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
                OutFabricValid <= 1'b1;
                OutFabric      <= Req[grantIdx];
            end else if (OutReady) begin
                OutFabricValid <= 1'b0;
            end
            RspValid    <= pop ? NUM_REQ'(1) << tagHead : '0;
            if (pop) RspData <= InFabric.data;
            ErrUnexpRsp <= ErrUnexpRsp || (rspHit && tagEmpty);
        end
    end

`ifdef CORE_RRV_FAB_ARB_PMON_EN
    logic tagFullBlock;

    assign tagFullBlock = tagFull && |(ReqValid & isRd);

    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            for (int j = 0; j < NUM_REQ; j++) PmonGrantCnt[j] <= '0;
            PmonStallCnt   <= '0;
            PmonTagFullCnt <= '0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++)
                if (grantValid && grantIdx == IW'(j) && PmonGrantCnt[j] != '1)
                    PmonGrantCnt[j] <= PmonGrantCnt[j] + 1'b1;
            if (OutFabricValid && !OutReady && PmonStallCnt != '1)
                PmonStallCnt <= PmonStallCnt + 1'b1;
            if (tagFullBlock && PmonTagFullCnt != '1)
                PmonTagFullCnt <= PmonTagFullCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_core_rrv_fab_req_arb.sv
// tb_core_rrv_fab_req_arb: directed self-checking bench for the fabric request arbiter
module tb_core_rrv_fab_req_arb;
    import core_rrv_pkg::*;

    logic        Clock, RstN, OutReady, InFabricValid, OutFabricValid, ErrUnexpRsp;
    logic [1:0]  ReqValid, ReqReady, RspValid;
    logic [31:0] RspData;
    logic [2:0]  TagCount;
    t_tile_trans Req [2];
    t_tile_trans OutFabric, InFabric;
`ifdef CORE_RRV_FAB_ARB_PMON_EN
    logic [31:0] PmonGrantCnt [2];
    logic [31:0] PmonStallCnt, PmonTagFullCnt;
`endif
    int passed = 0;
    int total  = 0;

    core_rrv_fab_req_arb dut (
        .Clock         (Clock),
        .RstN          (RstN),
        .ReqValid      (ReqValid),
        .Req           (Req),
        .ReqReady      (ReqReady),
        .OutFabricValid(OutFabricValid),
        .OutFabric     (OutFabric),
        .OutReady      (OutReady),
        .InFabricValid (InFabricValid),
        .InFabric      (InFabric),
        .RspValid      (RspValid),
        .RspData       (RspData),
        .ErrUnexpRsp   (ErrUnexpRsp),
        .TagCount      (TagCount)
`ifdef CORE_RRV_FAB_ARB_PMON_EN
        ,
        .PmonGrantCnt  (PmonGrantCnt),
        .PmonStallCnt  (PmonStallCnt),
        .PmonTagFullCnt(PmonTagFullCnt)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic t_tile_trans mk(t_tile_op op, logic [31:0] a, logic [31:0] d);
        t_tile_trans t;
        t.opcode = op;
        t.addr   = a;
        t.data   = d;
        return t;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        ReqValid = 2'b11;
        #12;
        total++; if (ReqReady !== 2'b00) $display("FAIL rst_ready got %b exp 00", ReqReady); else passed++;
        total++; if (OutFabricValid !== 1'b0) $display("FAIL rst_outvalid got %b exp 0", OutFabricValid); else passed++;
        total++; if (TagCount !== 3'd0) $display("FAIL rst_tagcount got %0d exp 0", TagCount); else passed++;
        total++; if ({ErrUnexpRsp, RspValid} !== 3'b000) $display("FAIL rst_rsp got %b exp 000", {ErrUnexpRsp, RspValid}); else passed++;
        ReqValid = 2'b00;
        @(negedge Clock);
        RstN = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  expRdy;
        logic [31:0] expAddr;
        Req[0]   = mk(WR, 32'h2200_0100, 32'h1);
        Req[1]   = mk(WR, 32'h2200_0200, 32'h2);
        ReqValid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            expRdy  = (i % 2 == 1) ? 2'b10 : 2'b01;
            expAddr = (i % 2 == 1) ? 32'h2200_0200 : 32'h2200_0100;
            #1;
            total++; if (ReqReady !== expRdy) $display("FAIL rr_ready[%0d] got %b exp %b", i, ReqReady, expRdy); else passed++;
            tick();
            total++; if ({OutFabricValid, OutFabric.addr} !== {1'b1, expAddr}) $display("FAIL rr_out[%0d] got %b/%h exp 1/%h", i, OutFabricValid, OutFabric.addr, expAddr); else passed++;
        end
        ReqValid = 2'b00;
        tick();
        total++; if (OutFabricValid !== 1'b0) $display("FAIL rr_idle got %b exp 0", OutFabricValid); else passed++;
    endtask

    task automatic test_rd_rsp();
        Req[0]   = mk(RD, 32'h2200_0010, 32'h0);
        Req[1]   = mk(RD, 32'h2200_0020, 32'h0);
        ReqValid = 2'b11;
        #1;
        total++; if (ReqReady !== 2'b01) $display("FAIL rd_grant0 got %b exp 01", ReqReady); else passed++;
        tick();
        ReqValid = 2'b10;
        #1;
        total++; if (ReqReady !== 2'b10) $display("FAIL rd_grant1 got %b exp 10", ReqReady); else passed++;
        total++; if (TagCount !== 3'd1) $display("FAIL rd_count1 got %0d exp 1", TagCount); else passed++;
        total++; if (OutFabric.addr !== 32'h2200_0010) $display("FAIL rd_addr0 got %h exp 22000010", OutFabric.addr); else passed++;
        tick();
        ReqValid = 2'b00;
        total++; if (TagCount !== 3'd2) $display("FAIL rd_count2 got %0d exp 2", TagCount); else passed++;
        total++; if ({OutFabric.opcode, OutFabric.addr} !== {RD, 32'h2200_0020}) $display("FAIL rd_addr1 got %h exp 22000020", OutFabric.addr); else passed++;
        InFabricValid = 1'b1;
        InFabric      = mk(RD_RSP, 32'h0, 32'hAAAA_0001);
        tick();
        total++; if ({RspValid, RspData} !== {2'b01, 32'hAAAA_0001}) $display("FAIL rsp0 got %b/%h exp 01/aaaa0001", RspValid, RspData); else passed++;
        total++; if (TagCount !== 3'd1) $display("FAIL rsp0_count got %0d exp 1", TagCount); else passed++;
        InFabric = mk(RD_RSP, 32'h0, 32'hBBBB_0002);
        tick();
        InFabricValid = 1'b0;
        total++; if ({RspValid, RspData} !== {2'b10, 32'hBBBB_0002}) $display("FAIL rsp1 got %b/%h exp 10/bbbb0002", RspValid, RspData); else passed++;
        total++; if (TagCount !== 3'd0) $display("FAIL rsp1_count got %0d exp 0", TagCount); else passed++;
        tick();
        total++; if (RspValid !== 2'b00) $display("FAIL rsp_pulse got %b exp 00", RspValid); else passed++;
    endtask

    task automatic test_tag_full();
        Req[0]   = mk(RD, 32'h2200_0030, 32'h0);
        ReqValid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (ReqReady !== 2'b01) $display("FAIL full_fill[%0d] got %b exp 01", i, ReqReady); else passed++;
            tick();
        end
        total++; if (TagCount !== 3'd4) $display("FAIL full_count got %0d exp 4", TagCount); else passed++;
        #1;
        total++; if (ReqReady !== 2'b00) $display("FAIL full_block got %b exp 00", ReqReady); else passed++;
        Req[1]   = mk(WR, 32'h2200_0044, 32'h0);
        ReqValid = 2'b11;
        #1;
        total++; if (ReqReady !== 2'b10) $display("FAIL full_wr got %b exp 10", ReqReady); else passed++;
        tick();
        total++; if (OutFabric.addr !== 32'h2200_0044) $display("FAIL full_wr_addr got %h exp 22000044", OutFabric.addr); else passed++;
        #1;
        total++; if (ReqReady !== 2'b10) $display("FAIL full_wr_prio got %b exp 10", ReqReady); else passed++;
        tick();
        ReqValid      = 2'b01;
        InFabricValid = 1'b1;
        InFabric      = mk(RD_RSP, 32'h0, 32'h5555_0005);
        #1;
        total++; if (ReqReady !== 2'b00) $display("FAIL full_nobypass got %b exp 00", ReqReady); else passed++;
        tick();
        InFabricValid = 1'b0;
        total++; if ({TagCount, RspValid} !== {3'd3, 2'b01}) $display("FAIL full_pop got %0d/%b exp 3/01", TagCount, RspValid); else passed++;
        #1;
        total++; if (ReqReady !== 2'b01) $display("FAIL full_fifth got %b exp 01", ReqReady); else passed++;
        tick();
        ReqValid = 2'b00;
        total++; if ({TagCount, OutFabric.opcode, OutFabric.addr} !== {3'd4, RD, 32'h2200_0030}) $display("FAIL full_fifth_out got %0d/%h exp 4/22000030", TagCount, OutFabric.addr); else passed++;
        InFabricValid = 1'b1;
        repeat (4) tick();
        InFabricValid = 1'b0;
        tick();
        total++; if ({TagCount, ErrUnexpRsp} !== {3'd0, 1'b0}) $display("FAIL full_drain got %0d/%b exp 0/0", TagCount, ErrUnexpRsp); else passed++;
    endtask

    task automatic test_backpressure();
        Req[0]   = mk(WR, 32'h2200_0004, 32'h0);
        ReqValid = 2'b01;
        #1;
        total++; if (ReqReady !== 2'b01) $display("FAIL bp_first got %b exp 01", ReqReady); else passed++;
        tick();
        OutReady = 1'b0;
        Req[0]   = mk(WR, 32'h2200_0008, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ReqReady !== 2'b00) $display("FAIL bp_ready[%0d] got %b exp 00", i, ReqReady); else passed++;
            tick();
            total++; if ({OutFabricValid, OutFabric.addr} !== {1'b1, 32'h2200_0004}) $display("FAIL bp_hold[%0d] got %b/%h exp 1/22000004", i, OutFabricValid, OutFabric.addr); else passed++;
        end
        OutReady = 1'b1;
        #1;
        total++; if (ReqReady !== 2'b01) $display("FAIL bp_release got %b exp 01", ReqReady); else passed++;
        tick();
        ReqValid = 2'b00;
        total++; if (OutFabric.addr !== 32'h2200_0008) $display("FAIL bp_next got %h exp 22000008", OutFabric.addr); else passed++;
        tick();
        total++; if (OutFabricValid !== 1'b0) $display("FAIL bp_idle got %b exp 0", OutFabricValid); else passed++;
    endtask

    task automatic test_unexp_rsp();
        InFabricValid = 1'b1;
        InFabric      = mk(WR, 32'h0, 32'h1234);
        tick();
        total++; if (ErrUnexpRsp !== 1'b0) $display("FAIL ign_wr got %b exp 0", ErrUnexpRsp); else passed++;
        InFabric = mk(RD_RSP, 32'h0, 32'hDEAD);
        tick();
        InFabricValid = 1'b0;
        total++; if ({ErrUnexpRsp, RspValid, TagCount} !== {1'b1, 2'b00, 3'd0}) $display("FAIL unexp got %b/%b/%0d exp 1/00/0", ErrUnexpRsp, RspValid, TagCount); else passed++;
        repeat (3) tick();
        total++; if (ErrUnexpRsp !== 1'b1) $display("FAIL unexp_sticky got %b exp 1", ErrUnexpRsp); else passed++;
    endtask

    task automatic test_reset_mid();
        Req[0]   = mk(RD, 32'h2200_0050, 32'h0);
        ReqValid = 2'b01;
        tick();
        tick();
        ReqValid = 2'b00;
        total++; if ({TagCount, OutFabricValid} !== {3'd2, 1'b1}) $display("FAIL mid_pre got %0d/%b exp 2/1", TagCount, OutFabricValid); else passed++;
`ifdef CORE_RRV_FAB_ARB_PMON_EN
        total++; if ({PmonGrantCnt[0], PmonGrantCnt[1], PmonStallCnt, PmonTagFullCnt} !== {32'd12, 32'd5, 32'd3, 32'd3}) $display("FAIL pmon_pre got %0d/%0d/%0d/%0d exp 12/5/3/3", PmonGrantCnt[0], PmonGrantCnt[1], PmonStallCnt, PmonTagFullCnt); else passed++;
`endif
        #2;
        RstN = 1'b0;
        #1;
        total++; if ({TagCount, OutFabricValid, ErrUnexpRsp} !== {3'd0, 1'b0, 1'b0}) $display("FAIL mid_async got %0d/%b/%b exp 0/0/0", TagCount, OutFabricValid, ErrUnexpRsp); else passed++;
`ifdef CORE_RRV_FAB_ARB_PMON_EN
        total++; if ({PmonGrantCnt[0], PmonGrantCnt[1], PmonStallCnt, PmonTagFullCnt} !== 128'd0) $display("FAIL pmon_rst got %0d/%0d/%0d/%0d exp 0", PmonGrantCnt[0], PmonGrantCnt[1], PmonStallCnt, PmonTagFullCnt); else passed++;
`endif
        @(negedge Clock);
        RstN = 1'b1;
        tick();
        InFabricValid = 1'b1;
        InFabric      = mk(RD_RSP, 32'h0, 32'h7777);
        tick();
        InFabricValid = 1'b0;
        total++; if ({ErrUnexpRsp, RspValid} !== {1'b1, 2'b00}) $display("FAIL mid_late got %b/%b exp 1/00", ErrUnexpRsp, RspValid); else passed++;
    endtask

    initial begin
        RstN          = 1'b0;
        ReqValid      = 2'b00;
        Req[0]        = mk(WR, 32'h0, 32'h0);
        Req[1]        = mk(WR, 32'h0, 32'h0);
        OutReady      = 1'b1;
        InFabricValid = 1'b0;
        InFabric      = mk(WR, 32'h0, 32'h0);
        test_reset();
        test_round_robin();
        test_rd_rsp();
        test_tag_full();
        test_backpressure();
        test_unexp_rsp();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_rrv_fab_req_arb.md
Name: core_rrv_fab_req_arb

Overview:
- Round-robin arbiter that shares the single core_rrv outbound fabric port (OutFabric/OutFabricValid) between NUM_REQ requesters, e.g. the core data path's remote load/store and the CR/debug DMA.
- Keeps an in-order tag FIFO of outstanding RD requests.
- Routes each returning RD_RSP on the inbound fabric to the requester that issued the matching read.
- Sits between the requesters and the tile fabric interface, inside core_rrv_top.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TAG_DEPTH, 4, max outstanding RD transactions; power of two

Ports:
Clock  in  1  core clock
RstN  in  1  asynchronous active-low reset
ReqValid  in  NUM_REQ  per-requester request valid
Req  in  NUM_REQ x t_tile_trans  per-requester transaction (opcode WR/RD)
ReqReady  out  NUM_REQ  per-requester accept; transfer when ReqValid[i]&&ReqReady[i]
OutFabricValid  out  1  outbound transaction valid
OutFabric  out  t_tile_trans  outbound transaction
OutReady  in  1  fabric accepts outbound transaction this cycle
InFabricValid  in  1  inbound transaction valid
InFabric  in  t_tile_trans  inbound transaction; only RD_RSP is consumed
RspValid  out  NUM_REQ  one-hot read-response strobe
RspData  out  32  read-response data
ErrUnexpRsp  out  1  sticky: RD_RSP arrived with no outstanding read
TagCount  out  $clog2(TAG_DEPTH)+1  outstanding RD count

Behaviour:
- Reset (RstN=0, async): all outputs 0, RR pointer=0, tag FIFO empty, output register invalid.
- Output stage is one register. Its state is held stable while OutFabricValid&&!OutReady; no change to OutFabric while stalled.
- Slot is free when !OutFabricValid || OutReady. At most one grant per cycle, and only when the slot is free.
- Eligible requester: ReqValid[i] && (Req[i].opcode!=RD || TagCount_eff<TAG_DEPTH).
  - TagCount_eff counts RD grants not yet answered.
  - A pop in the same cycle does not free a slot (no bypass).
- Grant goes to the first eligible requester searching from RR pointer upward mod NUM_REQ.
  - ReqReady[i] is combinational: it is high only for the granted i, in that same cycle.
  - RR pointer becomes (granted+1) mod NUM_REQ; it is unchanged when there is no grant.
- Latency: a request accepted in cycle N gives OutFabricValid in cycle N+1 with OutFabric equal to Req[i] unchanged.
- RD grant pushes requester index i to the tag FIFO in the grant cycle.
- InFabricValid && InFabric.opcode==RD_RSP:
  - FIFO non-empty: pop the head h; in the next cycle RspValid[h]=1 for 1 cycle and RspData=InFabric.data.
  - FIFO empty: drop the response and set ErrUnexpRsp (cleared only by reset).
- Other inbound opcodes are ignored.
- Simultaneous push and pop: both take effect; TagCount is unchanged.
- Full FIFO: only RD requesters are blocked; WR requesters remain grantable.
- Fabric backpressure: OutReady=0 blocks all grants; FIFO contents are unaffected.
- Requester may drop ReqValid without a grant; there is no lock.
- Reset mid-operation: outstanding tags, the pending output and any error are discarded; late RD_RSPs after reset set ErrUnexpRsp.

Optional Feature:
- Macro CORE_RRV_FAB_ARB_PMON_EN.
- Defined:
  - Adds output PmonGrantCnt (NUM_REQ x 32), per-requester grant counters.
  - Adds PmonStallCnt (32), counting cycles with OutFabricValid&&!OutReady.
  - Adds PmonTagFullCnt (32), counting cycles where a RD request was blocked by a full FIFO.
  - All counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package core_rrv_pkg: t_tile_trans, opcodes (WR, RD, RD_RSP), and FAB_ARB_NUM_REQ / FAB_ARB_TAG_DEPTH defaults.
- Sub-module core_rrv_fab_tag_fifo: synchronous FIFO of $clog2(NUM_REQ)-bit indices with push, pop, full, empty and count.
- The RR arbiter stays inline.

Test Plan:
- Both requesters issue WR continuously, OutReady=1 -> grants alternate 0,1,0,1; one OutFabricValid per cycle; addresses appear 1 cycle after acceptance.
- Req0 RD addr 0x2200_0010, Req1 RD addr 0x2200_0020; RD_RSP data 0xAAAA0001 then 0xBBBB0002 -> RspValid[0] with 0xAAAA0001, then RspValid[1] with 0xBBBB0002, each 1 cycle after its response.
- TAG_DEPTH=4: Req0 issues 5 RDs, no responses -> 4 accepted, TagCount=4, 5th ReqReady=0; a concurrent Req1 WR is still granted; one RD_RSP -> 5th RD granted on the following cycle.
- OutReady=0 for 3 cycles with a pending WR 0x2200_0004 -> OutFabric held constant, no ReqReady; OutReady=1 -> transfer, next grant the same cycle.
- RD_RSP with the FIFO empty -> ErrUnexpRsp=1, no RspValid, TagCount stays 0; remains 1 until RstN pulse.
- RstN asserted with 2 RDs outstanding -> TagCount=0, OutFabricValid=0 immediately (async); with PMON_EN, counters read 0.
